// File: rtl/clk_ratio_meter_pkg.sv
// Shared types and helpers for the divided-clock ratio meter.
package clk_ratio_meter_pkg;

  typedef enum logic {
    SEEK    = 1'b0,
    MEASURE = 1'b1
  } meter_state_t;

  localparam int unsigned DEF_CNT_W = 16;

  // All-ones pattern; the top slices its own CNT_W-wide saturation value from it.
  localparam logic [63:0] CNT_SAT_ALL = '1;

  function automatic int unsigned lock_cnt_w(input int unsigned lock_cnt);
    return $clog2(lock_cnt + 1);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer followed by an edge-detect register.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_async};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign o_level = sync_q[SYNC_STAGES-1];
  assign o_rise  = o_level & ~prev_q;
  assign o_fall  = ~o_level & prev_q;

endmodule

// File: rtl/clk_ratio_meter.sv
// Measures period and high time of a divided clock in i_clk cycles and flags lock.
module clk_ratio_meter
  import clk_ratio_meter_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_CNT    = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_div_clk,
  input  logic             i_clear,
  output logic [CNT_W-1:0] o_period,
  output logic [CNT_W-1:0] o_high,
  output logic             o_valid,
  output logic             o_locked,
  output logic             o_timeout
);

  localparam int               LW       = lock_cnt_w(LOCK_CNT);
  localparam logic [CNT_W-1:0] SAT      = CNT_SAT_ALL[CNT_W-1:0];
  localparam logic [CNT_W-1:0] SAT_M1   = SAT - 1'b1;
  localparam logic [LW-1:0]    LOCK_MAX = LW'(LOCK_CNT);

  logic level, rise, fall;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_async (i_div_clk),
    .o_level (level),
    .o_rise  (rise),
    .o_fall  (fall)
  );

  meter_state_t     state_q, state_d;
  logic [CNT_W-1:0] per_q, high_q;
  logic [CNT_W-1:0] period_q, high_out_q;
  logic             hi_run_q;
  logic [LW-1:0]    lock_q, lock_nxt;
  logic             valid_q, locked_q, timeout_q;
  logic             capture, sat_hit;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= SEEK;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (i_clear) begin
      state_d = SEEK;
    end else begin
      case (state_q)
        SEEK:    if (rise) state_d = MEASURE;
        MEASURE: if (!rise && per_q == SAT_M1) state_d = SEEK;
        default: state_d = SEEK;
      endcase
    end
  end

  // Capture / saturation strobes and the lock count a capture would produce.
  always_comb begin
    capture  = 1'b0;
    sat_hit  = 1'b0;
    lock_nxt = LW'(1);
    if (!i_clear && state_q == MEASURE) begin
      capture = rise;
      sat_hit = !rise && per_q == SAT_M1;
    end
    if (per_q == period_q)
      lock_nxt = (lock_q == LOCK_MAX) ? LOCK_MAX : lock_q + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      per_q      <= '0;
      high_q     <= '0;
      period_q   <= '0;
      high_out_q <= '0;
      hi_run_q   <= 1'b0;
      lock_q     <= '0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      valid_q <= capture;
      if (i_clear) begin
        per_q     <= '0;
        high_q    <= '0;
        hi_run_q  <= 1'b0;
        lock_q    <= '0;
        locked_q  <= 1'b0;
        timeout_q <= 1'b0;
      end else if (state_q == SEEK) begin
        // First rise only arms the counters; nothing is reported for it.
        per_q    <= rise ? CNT_W'(1) : '0;
        high_q   <= rise ? CNT_W'(1) : '0;
        hi_run_q <= rise;
      end else if (capture) begin
        period_q   <= per_q;
        high_out_q <= high_q;
        per_q      <= CNT_W'(1);
        high_q     <= CNT_W'(1);
        hi_run_q   <= 1'b1;
        lock_q     <= lock_nxt;
        locked_q   <= (lock_nxt == LOCK_MAX);
      end else if (sat_hit) begin
        per_q     <= SAT;
        timeout_q <= 1'b1;
        locked_q  <= 1'b0;
        lock_q    <= '0;
      end else begin
        per_q <= per_q + 1'b1;
        if (level && hi_run_q) high_q <= high_q + 1'b1;
        if (fall) hi_run_q <= 1'b0;
      end
    end
  end

  assign o_period  = period_q;
  assign o_high    = high_out_q;
  assign o_valid   = valid_q;
  assign o_locked  = locked_q;
  assign o_timeout = timeout_q;

endmodule

// File: tb/tb_clk_ratio_meter.sv
// Directed bench for clk_ratio_meter: vector table plus hand-written corner sequences.
`timescale 1ns/100ps
module tb_clk_ratio_meter;

  localparam int CW = 6;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_div_clk = 1'b0;
  logic          i_clear = 1'b0;
  logic [CW-1:0] o_period, o_high;
  logic          o_valid, o_locked, o_timeout;

  clk_ratio_meter #(.CNT_W(CW), .SYNC_STAGES(2), .LOCK_CNT(4)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_div_clk (i_div_clk),
    .i_clear   (i_clear),
    .o_period  (o_period),
    .o_high    (o_high),
    .o_valid   (o_valid),
    .o_locked  (o_locked),
    .o_timeout (o_timeout)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { int per; int hi; int lk; int cyc; } vrec_t;
  typedef struct { int hi; int lo; int reps; logic [7:0] lmask; } vec_t;

  vrec_t vq[$];
  int    cyc = 0;
  int    nchk = 0;
  int    nfail = 0;

  always @(negedge i_clk) begin
    cyc++;
    if (o_valid) vq.push_back('{int'(o_period), int'(o_high), int'(o_locked), cyc});
  end

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_per(input int hi, input int lo, input int reps);
    repeat (reps) begin
      i_div_clk = 1'b1;
      repeat (hi) @(negedge i_clk);
      i_div_clk = 1'b0;
      repeat (lo) @(negedge i_clk);
    end
  endtask

  task automatic pulse_clear();
    i_clear = 1'b1;
    @(negedge i_clk);
    i_clear = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_period"},  int'(o_period),  0);
    chk({tag, "_high"},    int'(o_high),    0);
    chk({tag, "_valid"},   int'(o_valid),   0);
    chk({tag, "_locked"},  int'(o_locked),  0);
    chk({tag, "_timeout"}, int'(o_timeout), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected end of test");
    $fatal(1);
  end

  initial begin
    vec_t tbl[4];
    int   k, c0, w;

    tbl[0] = '{4, 4, 6, 8'b0011_1000};  // div-8: lock on 4th valid
    tbl[1] = '{3, 3, 6, 8'b0011_1000};  // div-6: drops on first, re-locks 3 later
    tbl[2] = '{2, 3, 3, 8'b0000_0000};  // div-5: too short to lock
    tbl[3] = '{1, 1, 5, 8'b0001_1000};  // minimum period 2

    // Reset state
    repeat (3) @(negedge i_clk);
    chk_zero("reset");
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Divide-by-3 with 1.5-cycle high time, sub-cycle phase
    vq.delete();
    #2;
    repeat (30) begin
      i_div_clk = ~i_div_clk;
      #15;
    end
    repeat (4) @(negedge i_clk);
    chk("div3_count", vq.size(), 14);
    if (vq.size() > 0) begin
      chk("div3_high_range", int'(vq[0].hi == 1 || vq[0].hi == 2), 1);
      foreach (vq[i]) begin
        chk($sformatf("div3_period[%0d]", i), vq[i].per, 3);
        chk($sformatf("div3_high_const[%0d]", i), vq[i].hi, vq[0].hi);
        chk($sformatf("div3_locked[%0d]", i), vq[i].lk, int'(i >= 3));
        if (i > 0) chk($sformatf("div3_spacing[%0d]", i), vq[i].cyc - vq[i-1].cyc, 3);
      end
    end
    @(negedge i_clk);
    pulse_clear();

    // Table of synchronous divide ratios
    vq.delete();
    for (int r = 0; r < 4; r++) drive_per(tbl[r].hi, tbl[r].lo, tbl[r].reps);
    i_div_clk = 1'b1;
    repeat (4) @(negedge i_clk);
    i_div_clk = 1'b0;
    repeat (4) @(negedge i_clk);
    chk("tbl_count", vq.size(), 20);
    k = 0;
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < tbl[r].reps; j++) begin
        if (k < vq.size()) begin
          chk($sformatf("tbl%0d_period[%0d]", r, j), vq[k].per, tbl[r].hi + tbl[r].lo);
          chk($sformatf("tbl%0d_high[%0d]", r, j), vq[k].hi, tbl[r].hi);
          chk($sformatf("tbl%0d_locked[%0d]", r, j), vq[k].lk, int'(tbl[r].lmask[j]));
        end
        k++;
      end
    end

    // Stuck-low timeout, sticky through resumed toggling, cleared by i_clear
    drive_per(4, 4, 6);
    chk("to_pre_locked", int'(o_locked), 1);
    repeat (50) @(negedge i_clk);
    chk("to_not_early", int'(o_timeout), 0);
    w = 0;
    while (!o_timeout && w < 40) begin
      @(negedge i_clk);
      w++;
    end
    chk("to_set", int'(o_timeout), 1);
    chk("to_locked", int'(o_locked), 0);
    chk("to_hold_period", int'(o_period), 8);
    chk("to_hold_high", int'(o_high), 4);
    vq.delete();
    drive_per(4, 4, 4);
    chk("to_resume_valids", vq.size(), 3);
    chk("to_sticky", int'(o_timeout), 1);
    pulse_clear();
    chk("to_cleared", int'(o_timeout), 0);

    // i_clear coinciding with a rise strobe
    drive_per(4, 4, 2);
    i_div_clk = 1'b1;
    vq.delete();
    @(negedge i_clk);
    @(negedge i_clk);
    i_clear = 1'b1;
    @(negedge i_clk);
    i_clear = 1'b0;
    c0 = cyc;
    @(negedge i_clk);
    i_div_clk = 1'b0;
    repeat (4) @(negedge i_clk);
    drive_per(4, 4, 1);
    i_div_clk = 1'b1;
    repeat (4) @(negedge i_clk);
    i_div_clk = 1'b0;
    repeat (2) @(negedge i_clk);
    chk("clr_rise_count", vq.size(), 1);
    if (vq.size() > 0) begin
      chk("clr_rise_period", vq[0].per, 8);
      chk("clr_rise_latency", int'(vq[0].cyc - c0 >= 14 && vq[0].cyc - c0 <= 18), 1);
    end

    // Asynchronous reset mid-period while locked
    drive_per(4, 4, 6);
    chk("rst_pre_locked", int'(o_locked), 1);
    i_div_clk = 1'b1;
    repeat (2) @(negedge i_clk);
    #3 i_rst_n = 1'b0;
    #1 chk_zero("rst_mid");
    i_div_clk = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    vq.delete();
    repeat (4) @(negedge i_clk);
    drive_per(4, 4, 1);
    chk("rst_first_rise_silent", vq.size(), 0);
    i_div_clk = 1'b1;
    repeat (4) @(negedge i_clk);
    i_div_clk = 1'b0;
    repeat (4) @(negedge i_clk);
    chk("rst_second_rise_count", vq.size(), 1);
    if (vq.size() > 0) begin
      chk("rst_second_rise_period", vq[0].per, 8);
      chk("rst_second_rise_high", vq[0].hi, 4);
    end

    // Asynchronous 10.3-cycle divided clock
    pulse_clear();
    vq.delete();
    repeat (80) begin
      #51.5 i_div_clk = ~i_div_clk;
    end
    repeat (15) @(negedge i_clk);
    chk("async_count", int'(vq.size() >= 35), 1);
    foreach (vq[i]) chk($sformatf("async_period[%0d]", i), int'(vq[i].per == 10 || vq[i].per == 11), 1);
    chk("async_no_timeout", int'(o_timeout), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
